// File: rtl/move_ctrl_m.sv
// Turn controller and referee for board_m: validates moves, alternates X/O, scans win lines.
// Optional idle-turn forfeit is enabled by defining MOVE_TIMEOUT_EN.
`ifndef CELL_BLANK
`define CELL_BLANK 2'b00
`endif
`ifndef CELL_X
`define CELL_X 2'b01
`endif
`ifndef CELL_O
`define CELL_O 2'b10
`endif
`ifndef INDEX_T
`define INDEX_T [3:0]
`endif
`ifndef STATE_T
`define STATE_T [1:0]
`endif
`ifndef BOARD_T
`define BOARD_T [8:0]
`endif

module move_ctrl_m #(
  parameter logic [1:0] FIRST_PLAYER = `CELL_X
`ifdef MOVE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  move_valid,
  input  logic `INDEX_T         move_loc,
  output logic                  move_ready,
  output logic                  move_reject,
  input  logic `BOARD_T `STATE_T board,
  output logic `INDEX_T         update_loc,
  output logic `STATE_T         update_val,
  output logic                  board_reset,
  input  logic                  new_game,
  output logic `STATE_T         turn,
  output logic `STATE_T         winner,
  output logic                  game_over
);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, CHECK, OVER} state_t;

  state_t      state, next_state;
  logic [3:0]  loc_q;
  logic [2:0]  line_cnt;
  logic        win_flag;
  logic        handshake, loc_legal, line_match, board_full, win_now, timeout_hit;
  logic [1:0]  loc_cell, cell_a, cell_b, cell_c, other_player;

  always_comb begin
    loc_cell   = `CELL_BLANK;
    board_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (move_loc == 4'(i)) loc_cell = board[i];
      if (board[i] == `CELL_BLANK) board_full = 1'b0;
    end
  end

  assign loc_legal    = (move_loc < 4'd9) && (loc_cell == `CELL_BLANK);
  assign handshake    = move_valid && move_ready && !new_game;
  assign other_player = (turn == `CELL_X) ? `CELL_O : `CELL_X;

  // Line order: rows, columns, main diagonal, anti-diagonal
  always_comb begin
    cell_a = board[0];
    cell_b = board[1];
    cell_c = board[2];
    case (line_cnt)
      3'd0: begin cell_a = board[0]; cell_b = board[1]; cell_c = board[2]; end
      3'd1: begin cell_a = board[3]; cell_b = board[4]; cell_c = board[5]; end
      3'd2: begin cell_a = board[6]; cell_b = board[7]; cell_c = board[8]; end
      3'd3: begin cell_a = board[0]; cell_b = board[3]; cell_c = board[6]; end
      3'd4: begin cell_a = board[1]; cell_b = board[4]; cell_c = board[7]; end
      3'd5: begin cell_a = board[2]; cell_b = board[5]; cell_c = board[8]; end
      3'd6: begin cell_a = board[0]; cell_b = board[4]; cell_c = board[8]; end
      default: begin cell_a = board[2]; cell_b = board[4]; cell_c = board[6]; end
    endcase
  end

  assign line_match = (cell_a == turn) && (cell_b == turn) && (cell_c == turn);
  assign win_now    = win_flag || line_match;

`ifdef MOVE_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout_hit = (state == IDLE) && !handshake && !new_game &&
                       ((idle_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (new_game || state != IDLE || handshake || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  // board_reset is masked during reset so board_m sees the clear only after release
  always_comb begin
    next_state  = state;
    move_ready  = 1'b0;
    board_reset = 1'b0;
    update_loc  = 4'hF;
    update_val  = `CELL_BLANK;
    case (state)
      CLEAR: begin
        board_reset = !reset;
        next_state  = IDLE;
      end
      IDLE: begin
        move_ready = 1'b1;
        if (move_valid && loc_legal) next_state = WRITE;
      end
      WRITE: begin
        update_loc = loc_q;
        update_val = turn;
        next_state = CHECK;
      end
      CHECK: begin
        if (line_cnt == 3'd7) next_state = (win_now || board_full) ? OVER : IDLE;
      end
      default: next_state = OVER;
    endcase
    if (new_game) next_state = CLEAR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      turn        <= FIRST_PLAYER;
      winner      <= `CELL_BLANK;
      game_over   <= 1'b0;
      move_reject <= 1'b0;
      loc_q       <= '0;
      line_cnt    <= '0;
      win_flag    <= 1'b0;
    end else if (new_game) begin
      turn        <= FIRST_PLAYER;
      winner      <= `CELL_BLANK;
      game_over   <= 1'b0;
      move_reject <= 1'b0;
      line_cnt    <= '0;
      win_flag    <= 1'b0;
    end else begin
      move_reject <= (handshake && !loc_legal) || timeout_hit;
      if (handshake && loc_legal) loc_q <= move_loc;
      if (timeout_hit) turn <= other_player;
      case (state)
        WRITE: begin
          line_cnt <= '0;
          win_flag <= 1'b0;
        end
        CHECK: begin
          line_cnt <= line_cnt + 3'd1;
          win_flag <= win_now;
          if (line_cnt == 3'd7) begin
            if (win_now) begin
              winner    <= turn;
              game_over <= 1'b1;
            end else if (board_full) begin
              game_over <= 1'b1;
            end else begin
              turn <= other_player;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_ctrl_m.sv
// Self-checking bench for move_ctrl_m with a board_m model and a write/reject scoreboard.
`ifndef CELL_BLANK
`define CELL_BLANK 2'b00
`endif
`ifndef CELL_X
`define CELL_X 2'b01
`endif
`ifndef CELL_O
`define CELL_O 2'b10
`endif
`ifndef INDEX_T
`define INDEX_T [3:0]
`endif
`ifndef STATE_T
`define STATE_T [1:0]
`endif
`ifndef BOARD_T
`define BOARD_T [8:0]
`endif

module tb_move_ctrl_m;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   move_valid = 1'b0;
  logic `INDEX_T          move_loc = '0;
  logic                   new_game = 1'b0;
  logic                   move_ready, move_reject, board_reset, game_over;
  logic `INDEX_T          update_loc;
  logic `STATE_T          update_val, turn, winner;
  logic `BOARD_T `STATE_T board = '0;

  move_ctrl_m dut (
    .clock(clock), .reset(reset), .move_valid(move_valid), .move_loc(move_loc),
    .move_ready(move_ready), .move_reject(move_reject), .board(board),
    .update_loc(update_loc), .update_val(update_val), .board_reset(board_reset),
    .new_game(new_game), .turn(turn), .winner(winner), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Stand-in for board_m: clear pulse wins, otherwise write any in-range index
  always @(posedge clock) begin
    if (board_reset) board <= '0;
    else if (update_loc < 4'd9) board[update_loc] <= update_val;
  end

  typedef struct packed {
    logic       is_reject;
    logic [3:0] loc;
    logic [1:0] val;
  } exp_t;

  localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  exp_t       exp_q [$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [1:0] mdl_cells [16];
  logic [1:0] mdl_turn, mdl_winner;
  logic       mdl_over;
  logic       legal;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Every write or reject the DUT produces must match the oldest pending expectation
  always @(negedge clock) begin
    if (!reset && (update_loc != 4'hF || move_reject)) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_spurious", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_reject", move_reject, mon_e.is_reject);
        if (!mon_e.is_reject) begin
          checkOutput("sb_loc", update_loc, mon_e.loc);
          checkOutput("sb_val", update_val, mon_e.val);
        end
      end
    end
  end

  function automatic logic [1:0] mdlWinner();
    for (int l = 0; l < 8; l++)
      if (mdl_cells[LINES[l][0]] != `CELL_BLANK &&
          mdl_cells[LINES[l][0]] == mdl_cells[LINES[l][1]] &&
          mdl_cells[LINES[l][1]] == mdl_cells[LINES[l][2]])
        return mdl_cells[LINES[l][0]];
    return `CELL_BLANK;
  endfunction

  function automatic logic mdlFull();
    for (int i = 0; i < 9; i++)
      if (mdl_cells[i] == `CELL_BLANK) return 1'b0;
    return 1'b1;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 16; i++) mdl_cells[i] = `CELL_BLANK;
    mdl_turn   = `CELL_X;
    mdl_winner = `CELL_BLANK;
    mdl_over   = 1'b0;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!move_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!move_ready) checkOutput("ready_timeout", move_ready, 1);
  endtask

  task automatic sendMove(input logic [3:0] loc, output logic is_legal);
    waitReady();
    is_legal = (loc < 4'd9) && (mdl_cells[loc] == `CELL_BLANK);
    if (is_legal) begin
      exp_q.push_back('{is_reject: 1'b0, loc: loc, val: mdl_turn});
      mdl_cells[loc] = mdl_turn;
    end else begin
      exp_q.push_back('{is_reject: 1'b1, loc: 4'h0, val: 2'b00});
    end
    move_valid = 1'b1;
    move_loc   = loc;
    @(posedge clock);
    #1 move_valid = 1'b0;
  endtask

  task automatic finishMove(input logic is_legal);
    int lat = 0;
    logic [1:0] w;
    @(negedge clock);
    if (is_legal) begin
      while (!move_ready && lat < 20) begin
        lat++;
        @(negedge clock);
      end
      w = mdlWinner();
      if (w != `CELL_BLANK) begin
        mdl_winner = w;
        mdl_over   = 1'b1;
      end else if (mdlFull()) begin
        mdl_over = 1'b1;
      end else begin
        mdl_turn = (mdl_turn == `CELL_X) ? `CELL_O : `CELL_X;
      end
      checkOutput("move_latency", lat, mdl_over ? 20 : 9);
    end else begin
      @(negedge clock);
      checkOutput("ready_after_reject", move_ready, 1);
    end
    checkOutput("turn", turn, mdl_turn);
    checkOutput("winner", winner, mdl_winner);
    checkOutput("game_over", game_over, mdl_over);
  endtask

  task automatic applyStimulus(input logic [3:0] loc);
    logic l;
    sendMove(loc, l);
    finishMove(l);
  endtask

  task automatic newGame();
    @(negedge clock);
    new_game = 1'b1;
    @(posedge clock);
    #1 new_game = 1'b0;
    @(negedge clock);
    resetModel();
    checkOutput("clear_board_reset", board_reset, 1);
    checkOutput("clear_ready", move_ready, 0);
    checkOutput("clear_turn", turn, mdl_turn);
    checkOutput("clear_winner", winner, `CELL_BLANK);
    checkOutput("clear_game_over", game_over, 0);
    @(negedge clock);
    checkOutput("idle_ready", move_ready, 1);
    checkOutput("idle_board_reset", board_reset, 0);
    checkOutput("board_cleared", board, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetModel();
    @(negedge clock);
    checkOutput("rst_ready", move_ready, 0);
    checkOutput("rst_board_reset", board_reset, 0);
    checkOutput("rst_update_loc", update_loc, 4'hF);
    checkOutput("rst_update_val", update_val, `CELL_BLANK);
    checkOutput("rst_turn", turn, `CELL_X);
    checkOutput("rst_winner", winner, `CELL_BLANK);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_reject", move_reject, 0);
    reset = 1'b0;
    #1;
    checkOutput("first_board_reset", board_reset, 1);
    checkOutput("first_ready", move_ready, 0);
    @(negedge clock);
    checkOutput("second_ready", move_ready, 1);
    checkOutput("second_board_reset", board_reset, 0);

    $display("[TB] legal move and illegal requests");
    applyStimulus(4'd4);
    checkOutput("board4_x", board[4], `CELL_X);
    applyStimulus(4'd4);
    applyStimulus(4'd12);
    checkOutput("turn_after_rejects", turn, `CELL_O);

    $display("[TB] row-0 win for X");
    newGame();
    foreach (LINES[0][i]) begin end
    applyStimulus(4'd0);
    applyStimulus(4'd3);
    applyStimulus(4'd1);
    applyStimulus(4'd4);
    applyStimulus(4'd2);
    checkOutput("win_winner", winner, `CELL_X);
    move_valid = 1'b1;
    move_loc   = 4'd5;
    repeat (5) @(negedge clock);
    checkOutput("over_ready", move_ready, 0);
    checkOutput("over_game_over", game_over, 1);
    checkOutput("over_turn", turn, `CELL_X);
    move_valid = 1'b0;

    $display("[TB] draw game");
    newGame();
    applyStimulus(4'd0);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd4);
    applyStimulus(4'd3);
    applyStimulus(4'd5);
    applyStimulus(4'd7);
    applyStimulus(4'd6);
    applyStimulus(4'd8);
    checkOutput("draw_winner", winner, `CELL_BLANK);
    checkOutput("draw_game_over", game_over, 1);

    $display("[TB] new_game during CHECK of third move");
    newGame();
    applyStimulus(4'd0);
    applyStimulus(4'd3);
    sendMove(4'd1, legal);
    @(negedge clock);
    @(negedge clock);
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_loc   = 4'd5;
    @(posedge clock);
    #1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    resetModel();
    @(negedge clock);
    checkOutput("abort_board_reset", board_reset, 1);
    checkOutput("abort_turn", turn, `CELL_X);
    checkOutput("abort_winner", winner, `CELL_BLANK);
    checkOutput("abort_game_over", game_over, 0);
    @(negedge clock);
    checkOutput("abort_ready", move_ready, 1);
    repeat (3) @(negedge clock);
    checkOutput("abort_board_clear", board, 0);
    checkOutput("sb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_ctrl_m.md
Name: move_ctrl_m

Overview:
Turn controller and referee on the write side of the board state holder (board_m).
- Accepts player move requests over a valid/ready handshake and validates each one against the current board.
- Drives board_m's update_loc/update_val/reset inputs, alternates players X and O, scans the 8 win lines after every move, and reports win, draw and game-over.

Parameters:
FIRST_PLAYER, `CELL_X, cell value of the player who moves first after reset or new_game.
TIMEOUT_CYCLES, 255, idle cycles before a turn is forfeited; used only with MOVE_TIMEOUT_EN.

Ports:
clock  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-high reset.
move_valid  input  1  move request present.
move_loc  input  `INDEX_T (4)  requested cell, row-major index 0..8.
move_ready  output  1  controller can accept a move.
move_reject  output  1  one-cycle pulse: last accepted request was illegal.
board  input  `BOARD_T `STATE_T (9 x 2)  current board from board_m.
update_loc  output  `INDEX_T  write index to board_m; 4'hF when idle.
update_val  output  `STATE_T  write value to board_m; `CELL_BLANK when idle.
board_reset  output  1  one-cycle clear pulse to board_m.
new_game  input  1  restart request.
turn  output  `STATE_T  player to move (`CELL_X or `CELL_O).
winner  output  `STATE_T  winning player; `CELL_BLANK if none or draw.
game_over  output  1  game finished (win or draw).

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: state=CLEAR, move_ready=0, move_reject=0, update_loc=4'hF, update_val=`CELL_BLANK, board_reset=0, turn=FIRST_PLAYER, winner=`CELL_BLANK, game_over=0, line counter=0, win flag=0.
- Registered FSM with states CLEAR, IDLE, WRITE, CHECK, OVER.
- CLEAR: board_reset=1 for exactly one cycle, update_loc=4'hF; then IDLE. The first cycle after reset release is always CLEAR, because board_m has no reset of its own.
- IDLE: move_ready=1, which is asserted only in IDLE. A request is accepted on a posedge with move_valid & move_ready.
  - Legal move: move_loc<9 and board[move_loc]==`CELL_BLANK → next state WRITE, move_loc latched.
  - Illegal move: move_reject=1 for the following cycle; stay IDLE; turn unchanged.
- WRITE: exactly one cycle with update_loc=latched loc and update_val=turn. board_m captures the value at the closing edge. Next state CHECK, counter=0, win flag=0.
- CHECK: 8 cycles, one line per cycle, in this order: rows 0,1,2; cols 0,1,2; diag (0,4,8); anti-diag (2,4,6).
  - Win flag |= all three cells == turn.
  - After line 7: if win → winner=turn, game_over=1, OVER.
  - Else if no cell is `CELL_BLANK → draw: game_over=1, winner=`CELL_BLANK, OVER.
  - Else turn toggles X↔O → IDLE.
- Move latency: the accept edge is followed by 9 non-ready cycles; move_ready re-asserts on the 10th cycle.
- OVER: move_ready=0; outputs hold until new_game or reset.
- new_game, sampled at any posedge in any state: → CLEAR, clears turn/winner/game_over/win flag, aborts any in-progress WRITE/CHECK. It has priority over a simultaneous move handshake, which is not accepted.
- update_loc stays 4'hF in every state except WRITE, so board_m ignores it. Writing during a board_reset cycle is therefore impossible.
- The move index is 4 bits; values 9..15 are illegal and rejected, never wrapped.

Optional Feature:
Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter increments each cycle in IDLE without a handshake.
  - When it reaches TIMEOUT_CYCLES, the turn toggles (forfeit) and the counter clears. move_reject pulses for that one cycle.
  - The counter clears on any accepted request, on leaving IDLE, on new_game and on reset.
- Undefined: no counter; IDLE waits indefinitely.

Test Plan:
- Reset release: board_reset=1 on the first cycle, move_ready=1 from the second; turn=`CELL_X, winner=`CELL_BLANK, game_over=0.
- Move at loc 4 by X: update_loc=4/update_val=`CELL_X for exactly 1 cycle; move_ready low for 9 cycles; then turn=`CELL_O.
- Illegal requests: loc 4 again (occupied), then loc 12 → move_reject pulses 1 cycle each; no WRITE; turn unchanged.
- X plays 0,1,2 while O plays 3,4 → after X's 2 the row-0 line matches: winner=`CELL_X, game_over=1; move_valid is then ignored.
- Fill the board to a draw (X:0,2,3,7,8 O:1,4,5,6) → game_over=1, winner=`CELL_BLANK.
- new_game asserted during the CHECK of the 3rd move, together with move_valid → CLEAR, board_reset pulse, turn=FIRST_PLAYER, no further update_loc≠4'hF. With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=10: idle for 10 cycles → turn toggles and move_reject pulses once.
